// File: rtl/execute_stage_pkg.sv
// Shared encodings for the EX stage: M-extension funct3 values, operand-A
// select codes and the divider state enum.
package execute_stage_pkg;

  // RV32M funct3 encodings
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // Operand A select
  localparam logic [1:0] OPA_RS1  = 2'b00;
  localparam logic [1:0] OPA_PC   = 2'b01;
  localparam logic [1:0] OPA_ZERO = 2'b10;

  // Divider FSM state; visible as state_q inside iterative_divider
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } div_state_t;

endpackage

// File: rtl/iterative_divider.sv
// 32-cycle restoring divider for DIV/DIVU/REM/REMU. Works on magnitudes and
// applies the sign correction when the result is presented in DONE.
// Handshake: start is a level held by upstream for the whole operation; busy
// is combinational and high from the first start cycle through the last
// BUSY cycle; done is high for exactly one cycle (DONE) while result is valid.
module iterative_divider
  import execute_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_signed,
  input  logic        want_rem,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  div_state_t  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] quot_q, quot_d;      // dividend shifting out, quotient shifting in
  logic [31:0] rem_q, rem_d;        // partial remainder
  logic [31:0] div_q, div_d;        // divisor magnitude
  logic        neg_q_q, neg_q_d;    // negate quotient at the end
  logic        neg_r_q, neg_r_d;    // negate remainder at the end
  logic        want_rem_q, want_rem_d;

  logic [31:0] a_abs, b_abs;
  logic [32:0] shifted;

  assign a_abs   = (is_signed && a[31]) ? -a : a;
  assign b_abs   = (is_signed && b[31]) ? -b : b;
  assign shifted = {rem_q, quot_q[31]};

  // Next-state, operand latching and one restoring step per BUSY cycle
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    div_d      = div_q;
    neg_q_d    = neg_q_q;
    neg_r_d    = neg_r_q;
    want_rem_d = want_rem_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          want_rem_d = want_rem;
          if (b == 32'd0) begin
            // Divide by zero: results are final, no sign fixup
            quot_d  = 32'hFFFF_FFFF;
            rem_d   = a;
            neg_q_d = 1'b0;
            neg_r_d = 1'b0;
            state_d = DONE;
          end else if (is_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            // Signed overflow: results are final, no sign fixup
            quot_d  = 32'h8000_0000;
            rem_d   = 32'd0;
            neg_q_d = 1'b0;
            neg_r_d = 1'b0;
            state_d = DONE;
          end else begin
            quot_d  = a_abs;
            rem_d   = 32'd0;
            div_d   = b_abs;
            neg_q_d = is_signed & (a[31] ^ b[31]);
            neg_r_d = is_signed & a[31];
            cnt_d   = 5'd31;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (shifted >= {1'b0, div_q}) begin
          rem_d  = 32'(shifted - {1'b0, div_q});
          quot_d = {quot_q[30:0], 1'b1};
        end else begin
          rem_d  = shifted[31:0];
          quot_d = {quot_q[30:0], 1'b0};
        end
        if (cnt_q == 5'd0) state_d = DONE;
        else               cnt_d   = cnt_q - 5'd1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Divider state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 5'd0;
      quot_q     <= 32'd0;
      rem_q      <= 32'd0;
      div_q      <= 32'd0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      want_rem_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      div_q      <= div_d;
      neg_q_q    <= neg_q_d;
      neg_r_q    <= neg_r_d;
      want_rem_q <= want_rem_d;
    end
  end

  assign busy   = (state_q == IDLE && start) || (state_q == BUSY);
  assign done   = (state_q == DONE);
  assign result = want_rem_q ? (neg_r_q ? -rem_q : rem_q)
                             : (neg_q_q ? -quot_q : quot_q);

endmodule

// File: rtl/execute_stage.sv
// EX stage of the RV32IM pipeline: single-cycle ALU and multiplier, an
// iterative divider that stalls upstream, and the EX/MEM pipeline register.
// While ex_stall is high a zeroed bubble is written into EX/MEM.
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] rs1_data_IDEX,
  input  logic [WIDTH-1:0] rs2_data_IDEX,
  input  logic [WIDTH-1:0] imm_IDEX,
  input  logic [WIDTH-1:0] pc_IDEX,
  input  logic [WIDTH-1:0] pc_4_IDEX,
  input  logic [1:0]       op_a_sel_IDEX,
  input  logic             alu_src_IDEX,
  input  logic             alu_op_IDEX,
  input  logic [2:0]       funct3_IDEX,
  input  logic             funct7_5_IDEX,
  input  logic             is_mext_IDEX,
  input  logic             mem_wr_en_IDEX,
  input  logic             reg_wr_en_IDEX,
  input  logic [1:0]       reg_wr_ctrl_IDEX,
  input  logic [4:0]       rd_IDEX,
  output logic [WIDTH-1:0] ALU_out_EXMEM,
  output logic [2:0]       funct3_EXMEM,
  output logic             mem_wr_en_EXMEM,
  output logic [WIDTH-1:0] rs2_data_EXMEM,
  output logic             reg_wr_en_EXMEM,
  output logic [1:0]       reg_wr_ctrl_EXMEM,
  output logic [4:0]       rd_EXMEM,
  output logic [WIDTH-1:0] pc_4_EXMEM,
  output logic             ex_stall
);

  logic [31:0] op_a, op_b, alu_res, exe_res;
  logic [63:0] mul_a, mul_b, prod;
  logic        div_busy, div_done;
  logic [31:0] div_result;

  logic [31:0] alu_out_q, alu_out_d, rs2_data_q, rs2_data_d, pc_4_q, pc_4_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  reg_wr_ctrl_q, reg_wr_ctrl_d;
  logic [4:0]  rd_q, rd_d;
  logic        mem_wr_en_q, mem_wr_en_d, reg_wr_en_q, reg_wr_en_d;

  // Operand selection
  always_comb begin
    case (op_a_sel_IDEX)
      OPA_RS1: op_a = rs1_data_IDEX;
      OPA_PC:  op_a = pc_IDEX;
      default: op_a = 32'd0;
    endcase
    op_b = alu_src_IDEX ? imm_IDEX : rs2_data_IDEX;
  end

  // Multiplier: sign-extend per op then keep the low 64 bits of the product
  always_comb begin
    mul_a = {{32{op_a[31] & (funct3_IDEX[1:0] != 2'b11)}}, op_a};
    mul_b = {{32{op_b[31] & (funct3_IDEX[1:0] == 2'b01)}}, op_b};
    prod  = mul_a * mul_b;
  end

  // RV32I ALU and M-extension multiply result selection
  always_comb begin
    alu_res = op_a + op_b;
    if (alu_op_IDEX) begin
      case (funct3_IDEX)
        3'b000: alu_res = funct7_5_IDEX ? op_a - op_b : op_a + op_b;
        3'b001: alu_res = op_a << op_b[4:0];
        3'b010: alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
        3'b011: alu_res = {31'd0, op_a < op_b};
        3'b100: alu_res = op_a ^ op_b;
        3'b101: alu_res = funct7_5_IDEX ? 32'($signed(op_a) >>> op_b[4:0])
                                        : op_a >> op_b[4:0];
        3'b110: alu_res = op_a | op_b;
        default: alu_res = op_a & op_b;
      endcase
    end
    if (is_mext_IDEX && funct3_IDEX == F3_MUL) exe_res = prod[31:0];
    else if (is_mext_IDEX)                     exe_res = prod[63:32];
    else                                       exe_res = alu_res;
  end

  iterative_divider u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (is_mext_IDEX & funct3_IDEX[2]),
    .is_signed (~funct3_IDEX[0]),
    .want_rem  (funct3_IDEX[1]),
    .a         (op_a),
    .b         (op_b),
    .busy      (div_busy),
    .done      (div_done),
    .result    (div_result)
  );

  assign ex_stall = div_busy;

  // EX/MEM next values: bubble while stalled, divide result in DONE
  always_comb begin
    alu_out_d     = 32'd0;
    funct3_d      = 3'd0;
    mem_wr_en_d   = 1'b0;
    rs2_data_d    = 32'd0;
    reg_wr_en_d   = 1'b0;
    reg_wr_ctrl_d = 2'd0;
    rd_d          = 5'd0;
    pc_4_d        = 32'd0;
    if (!ex_stall) begin
      alu_out_d     = div_done ? div_result : exe_res;
      funct3_d      = funct3_IDEX;
      mem_wr_en_d   = mem_wr_en_IDEX;
      rs2_data_d    = rs2_data_IDEX;
      reg_wr_en_d   = reg_wr_en_IDEX;
      reg_wr_ctrl_d = reg_wr_ctrl_IDEX;
      rd_d          = rd_IDEX;
      pc_4_d        = pc_4_IDEX;
    end
  end

  // EX/MEM pipeline register
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_out_q     <= 32'd0;
      funct3_q      <= 3'd0;
      mem_wr_en_q   <= 1'b0;
      rs2_data_q    <= 32'd0;
      reg_wr_en_q   <= 1'b0;
      reg_wr_ctrl_q <= 2'd0;
      rd_q          <= 5'd0;
      pc_4_q        <= 32'd0;
    end else begin
      alu_out_q     <= alu_out_d;
      funct3_q      <= funct3_d;
      mem_wr_en_q   <= mem_wr_en_d;
      rs2_data_q    <= rs2_data_d;
      reg_wr_en_q   <= reg_wr_en_d;
      reg_wr_ctrl_q <= reg_wr_ctrl_d;
      rd_q          <= rd_d;
      pc_4_q        <= pc_4_d;
    end
  end

  assign ALU_out_EXMEM     = alu_out_q;
  assign funct3_EXMEM      = funct3_q;
  assign mem_wr_en_EXMEM   = mem_wr_en_q;
  assign rs2_data_EXMEM    = rs2_data_q;
  assign reg_wr_en_EXMEM   = reg_wr_en_q;
  assign reg_wr_ctrl_EXMEM = reg_wr_ctrl_q;
  assign rd_EXMEM          = rd_q;
  assign pc_4_EXMEM        = pc_4_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: ALU, multiplier, divider latency and
// stall/bubble behaviour, divider special cases and reset during a divide.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] rs1_data_IDEX, rs2_data_IDEX, imm_IDEX, pc_IDEX, pc_4_IDEX;
  logic [1:0]  op_a_sel_IDEX;
  logic        alu_src_IDEX, alu_op_IDEX, funct7_5_IDEX, is_mext_IDEX;
  logic [2:0]  funct3_IDEX;
  logic        mem_wr_en_IDEX, reg_wr_en_IDEX;
  logic [1:0]  reg_wr_ctrl_IDEX;
  logic [4:0]  rd_IDEX;
  logic [31:0] ALU_out_EXMEM, rs2_data_EXMEM, pc_4_EXMEM;
  logic [2:0]  funct3_EXMEM;
  logic        mem_wr_en_EXMEM, reg_wr_en_EXMEM, ex_stall;
  logic [1:0]  reg_wr_ctrl_EXMEM;
  logic [4:0]  rd_EXMEM;

  int tests_run    = 0;
  int tests_failed = 0;

  execute_stage dut (
    .clk               (clk),
    .reset             (reset),
    .rs1_data_IDEX     (rs1_data_IDEX),
    .rs2_data_IDEX     (rs2_data_IDEX),
    .imm_IDEX          (imm_IDEX),
    .pc_IDEX           (pc_IDEX),
    .pc_4_IDEX         (pc_4_IDEX),
    .op_a_sel_IDEX     (op_a_sel_IDEX),
    .alu_src_IDEX      (alu_src_IDEX),
    .alu_op_IDEX       (alu_op_IDEX),
    .funct3_IDEX       (funct3_IDEX),
    .funct7_5_IDEX     (funct7_5_IDEX),
    .is_mext_IDEX      (is_mext_IDEX),
    .mem_wr_en_IDEX    (mem_wr_en_IDEX),
    .reg_wr_en_IDEX    (reg_wr_en_IDEX),
    .reg_wr_ctrl_IDEX  (reg_wr_ctrl_IDEX),
    .rd_IDEX           (rd_IDEX),
    .ALU_out_EXMEM     (ALU_out_EXMEM),
    .funct3_EXMEM      (funct3_EXMEM),
    .mem_wr_en_EXMEM   (mem_wr_en_EXMEM),
    .rs2_data_EXMEM    (rs2_data_EXMEM),
    .reg_wr_en_EXMEM   (reg_wr_en_EXMEM),
    .reg_wr_ctrl_EXMEM (reg_wr_ctrl_EXMEM),
    .rd_EXMEM          (rd_EXMEM),
    .pc_4_EXMEM        (pc_4_EXMEM),
    .ex_stall          (ex_stall)
  );

  // Clock and global watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    rs1_data_IDEX = 0; rs2_data_IDEX = 0; imm_IDEX = 0; pc_IDEX = 0; pc_4_IDEX = 0;
    op_a_sel_IDEX = 0; alu_src_IDEX = 0; alu_op_IDEX = 0; funct3_IDEX = 0;
    funct7_5_IDEX = 0; is_mext_IDEX = 0; mem_wr_en_IDEX = 0; reg_wr_en_IDEX = 0;
    reg_wr_ctrl_IDEX = 0; rd_IDEX = 0;
  endtask

  task automatic drive(input logic [1:0] opa, input logic src, input logic aop,
                       input logic [2:0] f3, input logic f7, input logic mext,
                       input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im);
    op_a_sel_IDEX = opa; alu_src_IDEX = src; alu_op_IDEX = aop; funct3_IDEX = f3;
    funct7_5_IDEX = f7; is_mext_IDEX = mext;
    rs1_data_IDEX = r1; rs2_data_IDEX = r2; imm_IDEX = im;
    pc_IDEX = 32'h0000_1000; pc_4_IDEX = 32'h0000_1004;
    mem_wr_en_IDEX = 1'b0; reg_wr_en_IDEX = 1'b1; reg_wr_ctrl_IDEX = 2'b01; rd_IDEX = 5'd7;
  endtask

  // Counts stall cycles (bounded) and records whether every stalled cycle
  // left a zeroed bubble in EX/MEM. Ends in the first non-stalled cycle.
  task automatic wait_stall(output int n, output bit ok);
    n  = 0;
    ok = 1'b1;
    #1;
    while (ex_stall === 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (reg_wr_en_EXMEM !== 1'b0 || mem_wr_en_EXMEM !== 1'b0 ||
          ALU_out_EXMEM !== 32'd0 || rd_EXMEM !== 5'd0) ok = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    drive(2'b00, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFD);
    tick();
    tick();
    tests_run++;
    if (ALU_out_EXMEM !== 32'd0) begin
      tests_failed++; $display("FAIL reset_alu_out: got %h expected 00000000", ALU_out_EXMEM);
    end
    tests_run++;
    if ({reg_wr_en_EXMEM, mem_wr_en_EXMEM, rd_EXMEM, funct3_EXMEM, reg_wr_ctrl_EXMEM} !== 12'd0) begin
      tests_failed++; $display("FAIL reset_ctrl: got wr=%b mem=%b rd=%0d f3=%0d ctrl=%0d expected all 0",
                               reg_wr_en_EXMEM, mem_wr_en_EXMEM, rd_EXMEM, funct3_EXMEM, reg_wr_ctrl_EXMEM);
    end
    tests_run++;
    if (pc_4_EXMEM !== 32'd0 || rs2_data_EXMEM !== 32'd0) begin
      tests_failed++; $display("FAIL reset_data: got pc4=%h rs2=%h expected 0", pc_4_EXMEM, rs2_data_EXMEM);
    end
    reset = 1'b0;
    bubble();
    #1;
    tests_run++;
    if (ex_stall !== 1'b0) begin
      tests_failed++; $display("FAIL reset_stall: got %b expected 0", ex_stall);
    end
    tick();
  endtask

  task automatic test_add();
    drive(2'b00, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFD);
    #1;
    tests_run++;
    if (ex_stall !== 1'b0) begin
      tests_failed++; $display("FAIL add_stall: got %b expected 0", ex_stall);
    end
    tick();
    tests_run++;
    if (ALU_out_EXMEM !== 32'd2) begin
      tests_failed++; $display("FAIL add_imm: got %h expected 00000002", ALU_out_EXMEM);
    end
    tests_run++;
    if (reg_wr_en_EXMEM !== 1'b1 || rd_EXMEM !== 5'd7 || pc_4_EXMEM !== 32'h1004 ||
        reg_wr_ctrl_EXMEM !== 2'b01) begin
      tests_failed++; $display("FAIL add_passthru: got wr=%b rd=%0d pc4=%h ctrl=%b expected 1 7 00001004 01",
                               reg_wr_en_EXMEM, rd_EXMEM, pc_4_EXMEM, reg_wr_ctrl_EXMEM);
    end
  endtask

  task automatic test_alu();
    drive(2'b00, 1'b0, 1'b1, 3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'd4, 32'd0);
    tick();
    tests_run++;
    if (ALU_out_EXMEM !== 32'hF800_0000) begin
      tests_failed++; $display("FAIL sra: got %h expected f8000000", ALU_out_EXMEM);
    end
    drive(2'b00, 1'b0, 1'b1, 3'b101, 1'b0, 1'b0, 32'h8000_0000, 32'd4, 32'd0);
    tick();
    tests_run++;
    if (ALU_out_EXMEM !== 32'h0800_0000) begin
      tests_failed++; $display("FAIL srl: got %h expected 08000000", ALU_out_EXMEM);
    end
    drive(2'b00, 1'b0, 1'b1, 3'b011, 1'b0, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd0);
    tick();
    tests_run++;
    if (ALU_out_EXMEM !== 32'd1) begin
      tests_failed++; $display("FAIL sltu: got %h expected 00000001", ALU_out_EXMEM);
    end
    drive(2'b00, 1'b0, 1'b1, 3'b010, 1'b0, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd0);
    tick();
    tests_run++;
    if (ALU_out_EXMEM !== 32'd0) begin
      tests_failed++; $display("FAIL slt: got %h expected 00000000", ALU_out_EXMEM);
    end
    drive(2'b00, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 32'd5, 32'd7, 32'd0);
    tick();
    tests_run++;
    if (ALU_out_EXMEM !== 32'hFFFF_FFFE) begin
      tests_failed++; $display("FAIL sub: got %h expected fffffffe", ALU_out_EXMEM);
    end
    // PC-relative add with alu_op=0 (funct3 ignored) and a store
    drive(2'b01, 1'b1, 1'b0, 3'b110, 1'b0, 1'b0, 32'd0, 32'hCAFE_0001, 32'h100);
    mem_wr_en_IDEX = 1'b1;
    tick();
    tests_run++;
    if (ALU_out_EXMEM !== 32'h0000_1100 || mem_wr_en_EXMEM !== 1'b1 ||
        rs2_data_EXMEM !== 32'hCAFE_0001 || funct3_EXMEM !== 3'b110) begin
      tests_failed++; $display("FAIL pc_add_store: got out=%h mem=%b rs2=%h f3=%0d expected 00001100 1 cafe0001 6",
                               ALU_out_EXMEM, mem_wr_en_EXMEM, rs2_data_EXMEM, funct3_EXMEM);
    end
    drive(2'b10, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 32'd99, 32'd0, 32'h1234_5000);
    tick();
    tests_run++;
    if (ALU_out_EXMEM !== 32'h1234_5000) begin
      tests_failed++; $display("FAIL opa_zero: got %h expected 12345000", ALU_out_EXMEM);
    end
  endtask

  task automatic test_mul();
    drive(2'b00, 1'b0, 1'b1, 3'b001, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'd3, 32'd0);
    tick();
    tests_run++;
    if (ALU_out_EXMEM !== 32'hFFFF_FFFF) begin
      tests_failed++; $display("FAIL mulh: got %h expected ffffffff", ALU_out_EXMEM);
    end
    drive(2'b00, 1'b0, 1'b1, 3'b011, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    tick();
    tests_run++;
    if (ALU_out_EXMEM !== 32'hFFFF_FFFE) begin
      tests_failed++; $display("FAIL mulhu: got %h expected fffffffe", ALU_out_EXMEM);
    end
    drive(2'b00, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1, 32'd7, 32'hFFFF_FFFD, 32'd0);
    tick();
    tests_run++;
    if (ALU_out_EXMEM !== 32'hFFFF_FFEB) begin
      tests_failed++; $display("FAIL mul: got %h expected ffffffeb", ALU_out_EXMEM);
    end
    // MULHSU(-1, 0xFFFFFFFF): -(2^32-1) -> high word 0xFFFFFFFF
    drive(2'b00, 1'b0, 1'b1, 3'b010, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    tick();
    tests_run++;
    if (ALU_out_EXMEM !== 32'hFFFF_FFFF) begin
      tests_failed++; $display("FAIL mulhsu: got %h expected ffffffff", ALU_out_EXMEM);
    end
    // MULH(0xFFFFFFFF, 0xFFFFFFFF) = (-1)*(-1) = 1 -> high word 0
    drive(2'b00, 1'b0, 1'b1, 3'b001, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    tick();
    tests_run++;
    if (ALU_out_EXMEM !== 32'd0) begin
      tests_failed++; $display("FAIL mulh_neg: got %h expected 00000000", ALU_out_EXMEM);
    end
    bubble();
    tick();
  endtask

  task automatic test_div_signed();
    int n;
    bit ok;
    drive(2'b00, 1'b0, 1'b1, 3'b100, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'd0);
    wait_stall(n, ok);
    tests_run++;
    if (n !== 33) begin
      tests_failed++; $display("FAIL div_stall_len: got %0d cycles expected 33", n);
    end
    tests_run++;
    if (ok !== 1'b1) begin
      tests_failed++; $display("FAIL div_bubble: got non-zero EX/MEM during stall expected bubbles");
    end
    tick();
    tests_run++;
    if (ALU_out_EXMEM !== 32'hFFFF_FFFD || reg_wr_en_EXMEM !== 1'b1) begin
      tests_failed++; $display("FAIL div_result: got %h wr=%b expected fffffffd wr=1", ALU_out_EXMEM, reg_wr_en_EXMEM);
    end
    // Back-to-back: REM starts in the cycle after DONE
    drive(2'b00, 1'b0, 1'b1, 3'b110, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'd0);
    wait_stall(n, ok);
    tests_run++;
    if (n !== 33) begin
      tests_failed++; $display("FAIL rem_stall_len: got %0d cycles expected 33", n);
    end
    tick();
    tests_run++;
    if (ALU_out_EXMEM !== 32'hFFFF_FFFF) begin
      tests_failed++; $display("FAIL rem_result: got %h expected ffffffff", ALU_out_EXMEM);
    end
    // REMU 0xFFFFFFF9 % 16 = 9
    drive(2'b00, 1'b0, 1'b1, 3'b111, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd16, 32'd0);
    wait_stall(n, ok);
    tick();
    tests_run++;
    if (ALU_out_EXMEM !== 32'd9) begin
      tests_failed++; $display("FAIL remu_result: got %h expected 00000009", ALU_out_EXMEM);
    end
    bubble();
    tick();
  endtask

  task automatic test_div_special();
    int n;
    bit ok;
    drive(2'b00, 1'b0, 1'b1, 3'b101, 1'b0, 1'b1, 32'd9, 32'd0, 32'd0);
    wait_stall(n, ok);
    tests_run++;
    if (n !== 1) begin
      tests_failed++; $display("FAIL divu0_stall_len: got %0d cycles expected 1", n);
    end
    tick();
    tests_run++;
    if (ALU_out_EXMEM !== 32'hFFFF_FFFF) begin
      tests_failed++; $display("FAIL divu0_result: got %h expected ffffffff", ALU_out_EXMEM);
    end
    drive(2'b00, 1'b0, 1'b1, 3'b110, 1'b0, 1'b1, 32'd9, 32'd0, 32'd0);
    wait_stall(n, ok);
    tests_run++;
    if (n !== 1) begin
      tests_failed++; $display("FAIL rem0_stall_len: got %0d cycles expected 1", n);
    end
    tick();
    tests_run++;
    if (ALU_out_EXMEM !== 32'd9) begin
      tests_failed++; $display("FAIL rem0_result: got %h expected 00000009", ALU_out_EXMEM);
    end
    drive(2'b00, 1'b0, 1'b1, 3'b100, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    wait_stall(n, ok);
    tests_run++;
    if (n !== 1) begin
      tests_failed++; $display("FAIL divovf_stall_len: got %0d cycles expected 1", n);
    end
    tick();
    tests_run++;
    if (ALU_out_EXMEM !== 32'h8000_0000) begin
      tests_failed++; $display("FAIL divovf_result: got %h expected 80000000", ALU_out_EXMEM);
    end
    drive(2'b00, 1'b0, 1'b1, 3'b110, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    wait_stall(n, ok);
    tick();
    tests_run++;
    if (ALU_out_EXMEM !== 32'd0) begin
      tests_failed++; $display("FAIL removf_result: got %h expected 00000000", ALU_out_EXMEM);
    end
    bubble();
    tick();
  endtask

  task automatic test_reset_busy();
    int n;
    bit ok;
    drive(2'b00, 1'b0, 1'b1, 3'b101, 1'b0, 1'b1, 32'd100, 32'd7, 32'd0);
    for (int i = 0; i < 10; i++) tick();
    tests_run++;
    if (ex_stall !== 1'b1) begin
      tests_failed++; $display("FAIL busy_stall: got %b expected 1", ex_stall);
    end
    reset = 1'b1;
    bubble();
    tick();
    reset = 1'b0;
    #1;
    tests_run++;
    if (ALU_out_EXMEM !== 32'd0 || reg_wr_en_EXMEM !== 1'b0 || ex_stall !== 1'b0 ||
        pc_4_EXMEM !== 32'd0 || rd_EXMEM !== 5'd0) begin
      tests_failed++; $display("FAIL reset_busy: got out=%h wr=%b stall=%b pc4=%h rd=%0d expected all 0",
                               ALU_out_EXMEM, reg_wr_en_EXMEM, ex_stall, pc_4_EXMEM, rd_EXMEM);
    end
    drive(2'b00, 1'b0, 1'b1, 3'b101, 1'b0, 1'b1, 32'd100, 32'd7, 32'd0);
    wait_stall(n, ok);
    tests_run++;
    if (n !== 33) begin
      tests_failed++; $display("FAIL divu_after_reset_len: got %0d cycles expected 33", n);
    end
    tick();
    tests_run++;
    if (ALU_out_EXMEM !== 32'd14) begin
      tests_failed++; $display("FAIL divu_after_reset: got %h expected 0000000e", ALU_out_EXMEM);
    end
    bubble();
    tick();
  endtask

  // Test sequence and final report
  initial begin
    reset = 1'b1;
    bubble();
    test_reset();
    test_add();
    test_alu();
    test_mul();
    test_div_signed();
    test_div_special();
    test_reset_busy();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
